// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: latches floor requests, serves them in SCAN order
// and sequences floor-to-floor travel and door dwell off a shared tick strobe.
module elevator_car_ctrl #(
    parameter int FLOORS       = 8,
    parameter int FW           = 3,
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 6,
    parameter int CW           = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [FLOORS-1:0] req,
    output logic [FW-1:0]     floor,
    output logic              dir_up,
    output logic              moving,
    output logic              door_open,
    output logic              arrive,
    output logic [FLOORS-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    localparam logic [FW-1:0]     TOP_FLOOR   = FW'(FLOORS - 1);
    localparam logic [CW-1:0]     TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
    localparam logic [CW-1:0]     DOOR_LAST   = CW'(DOOR_TICKS - 1);
    localparam logic [FLOORS-1:0] ONE         = FLOORS'(1);

    state_t            state;
    logic [CW-1:0]     timer;
    logic [FLOORS-1:0] active;
    logic [FLOORS-1:0] above_cur;
    logic [FLOORS-1:0] below_cur;
    logic [FLOORS-1:0] above_next;
    logic [FLOORS-1:0] below_next;
    logic [FW-1:0]     floor_step;
    logic              any_above;
    logic              any_below;
    logic              here_active;
    logic              here_req;
    logic              stop_step;
    logic              beyond_step;
    logic              at_end;

    // Requests arriving this cycle count as if already latched.
    assign active      = pending | req;
    assign floor_step  = dir_up ? (floor + 1'b1) : (floor - 1'b1);
    assign at_end      = dir_up ? (floor == TOP_FLOOR) : (floor == '0);
    assign here_active = |(active & (ONE << floor));
    assign here_req    = |(req & (ONE << floor));
    assign stop_step   = |(active & (ONE << floor_step));
    assign any_above   = |(active & above_cur);
    assign any_below   = |(active & below_cur);
    assign beyond_step = dir_up ? |(active & above_next) : |(active & below_next);

    always_comb begin
        above_cur  = '0;
        below_cur  = '0;
        above_next = '0;
        below_next = '0;
        for (int i = 0; i < FLOORS; i++) begin
            above_cur[i]  = (i > int'(floor));
            below_cur[i]  = (i < int'(floor));
            above_next[i] = (i > int'(floor) + 1);
            below_next[i] = (i < int'(floor) - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            floor     <= '0;
            dir_up    <= 1'b1;
            timer     <= '0;
            pending   <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
            arrive    <= 1'b0;
        end else begin
            arrive  <= 1'b0;
            pending <= active;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (here_active) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        pending   <= active & ~(ONE << floor);
                    end else if (dir_up ? any_above : any_below) begin
                        state  <= MOVE;
                        moving <= 1'b1;
                    end else if (dir_up ? any_below : any_above) begin
                        dir_up <= ~dir_up;
                        state  <= MOVE;
                        moving <= 1'b1;
                    end
                end
                MOVE: begin
                    if (at_end) begin
                        state  <= IDLE;
                        moving <= 1'b0;
                        timer  <= '0;
                    end else if (tick) begin
                        if (timer == TRAVEL_LAST) begin
                            timer  <= '0;
                            floor  <= floor_step;
                            arrive <= 1'b1;
                            // Ends of the shaft force the only legal direction.
                            if (floor_step == '0) begin
                                dir_up <= 1'b1;
                            end else if (floor_step == TOP_FLOOR) begin
                                dir_up <= 1'b0;
                            end
                            if (stop_step) begin
                                state     <= DOOR;
                                moving    <= 1'b0;
                                door_open <= 1'b1;
                                pending   <= active & ~(ONE << floor_step);
                            end else if (!beyond_step) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                DOOR: begin
                    pending <= active & ~(ONE << floor);
                    // A button press at this floor restarts the dwell, even on the expiry tick.
                    if (here_req) begin
                        timer <= '0;
                    end else if (tick) begin
                        if (timer == DOOR_LAST) begin
                            state     <= IDLE;
                            door_open <= 1'b0;
                            timer     <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                    timer     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Single-car elevator controller. Latches floor requests, schedules service in SCAN order (serve all stops in the current direction, then reverse), and sequences floor-to-floor travel and door dwell.
- All timing uses internal tick-driven counters.
- Sits above the wait-timer datapath. It drives the floor indicator, motion and door outputs consumed by the display and motor/door logic.

Parameters:
- FLOORS, 8, number of floors (2..16); floors are numbered 0..FLOORS-1.
- FW, 3, floor index width; must satisfy 2^FW >= FLOORS.
- TRAVEL_TICKS, 3, ticks needed to move one floor (>=1).
- DOOR_TICKS, 6, ticks the door stays open (>=1).
- CW, 3, timer width; must hold max(TRAVEL_TICKS, DOOR_TICKS)-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle timebase strobe; timers advance only when tick=1.
- req  in  FLOORS  request pulses, car and hall buttons merged; bit i = floor i.
- floor  out  FW  current floor, or last floor passed while moving.
- dir_up  out  1  current or preferred direction; 1=up.
- moving  out  1  car in MOVE state.
- door_open  out  1  car in DOOR state.
- arrive  out  1  one-cycle pulse when floor changes.
- pending  out  FLOORS  latched unserved requests.

Behaviour:
- Reset, synchronous: on the next edge set state=IDLE, floor=0, dir_up=1, timer=0, pending=0, and moving=door_open=arrive=0. Reset mid-MOVE or mid-DOOR aborts immediately. Requests arriving in the reset cycle are dropped.
- Request latch, every cycle: pending <= (pending | req) & ~serve.
  - serve is the one-hot of floor, asserted in the cycle the FSM enters DOOR and in every cycle it stays in DOOR.
  - A req for the current floor while in DOOR is therefore never latched.
- States:
  - IDLE:
    - If pending[floor] | req[floor]: go to DOOR next edge, timer=0.
    - Else if the OR of pending|req strictly in direction dir_up is nonzero: go to MOVE, keeping dir_up.
    - Else if the OR of pending|req in the opposite direction is nonzero: flip dir_up and go to MOVE.
    - Else stay in IDLE.
    - Tie rule: requests both above and below resolve to the current dir_up.
  - MOVE:
    - On tick, if timer==TRAVEL_TICKS-1: floor +/-1 per dir_up, timer=0, arrive=1 for that cycle.
    - Otherwise on tick: timer+1.
    - On the arrival edge, if pending[new floor] (including a req in the same cycle): go to DOOR, timer=0.
    - Else if requests remain beyond the new floor in dir_up: stay in MOVE.
    - Else go to IDLE (defensive; unreachable in normal use).
    - A req for the floor just departed is latched and served on a later pass.
  - DOOR:
    - door_open=1.
    - On tick, timer+1. When timer==DOOR_TICKS-1 on tick: go to IDLE, timer=0.
    - req[floor] during DOOR restarts the dwell (timer=0). If it coincides with the expiry tick, the restart wins.
- Boundaries:
  - floor never goes below 0 or above FLOORS-1. Direction selection cannot choose a move past an end; if it would, stay in IDLE.
  - At floor 0, dir_up is forced to 1 on arrival. At floor FLOORS-1, dir_up is forced to 0 on arrival.
- Outputs: all registered. moving and door_open are state decodes and are never both 1. arrive is registered, one cycle.
- Latency: IDLE to MOVE or DOOR is 1 clk after the request is seen. Floor travel takes exactly TRAVEL_TICKS ticks. Dwell takes exactly DOOR_TICKS ticks, measured from the last restart.

Test Plan (FLOORS=8, TRAVEL_TICKS=3, DOOR_TICKS=6; tick every 4 clk):
- Reset, then req[3] pulse -> next edge moving=1, dir_up=1. floor steps 1, 2, 3 after 3, 6, 9 ticks, with arrive pulsing each step. At floor 3: door_open=1, pending[3]=0. door_open holds for 6 ticks, then IDLE with all outputs quiet.
- Car idle at 0, req[0] -> door_open=1 next edge. pending stays 0. IDLE after 6 ticks.
- Car moving up from 5 toward 7 (pending[7]=1); mid-travel, req[2] and req[6] in the same cycle -> stops at 6 then 7 (dir_up forced 0 at top), then travels down and stops at 2. Service order is 6, 7, 2.
- In DOOR at floor 3 after 2 ticks, req[3] -> timer restarts; door stays open 6 more ticks (8 total); pending[3] never set.
- Car idle at 4 with dir_up=0, req[2] and req[6] in the same cycle -> moves down, serves 2, then reverses and serves 6.
- Reset asserted while moving between floors 4 and 5 with pending=8'b1010_0000 -> next edge floor=0, pending=0, moving=0, door_open=0, dir_up=1. No further motion without a new req.
